clk_div_sched: RTL and testbench
================================

CLK_DIV_SCHED -- requirements
Module: clk_div_sched

Interface
REQ-001 The block SHALL have parameter W, default 16, the width of the divisor and the counter.
REQ-002 The block SHALL have parameter DEF_DIV, default 5, the divisor loaded at reset (legal range 2..2^W-1).
REQ-003 Port clk_in  input  1: the single clock; all flops SHALL update on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port run  input  1: level request; 1 = generate ticks, 0 = stop.
REQ-006 Port cfg_valid  input  1: a new divisor is offered on cfg_div.
REQ-007 Port cfg_div  input  W: the offered divisor value.
REQ-008 Port cfg_ready  output  1: the block can accept a divisor this cycle.
REQ-009 Port tick  output  1: one-cycle pulse at the start of each divided period.
REQ-010 Port phase  output  1: divided-clock-level enable, high in the first half of each period.
REQ-011 Port cur_div  output  W: the divisor currently in effect.
REQ-012 Port cfg_err  output  1: one-cycle pulse when an illegal divisor (0 or 1) is offered.
REQ-013 Port busy  output  1: high while the block is in RUN.

Function
REQ-014 All outputs SHALL be driven from flops; there SHALL be no combinational path from any input to any output.
REQ-015 The FSM SHALL have exactly two states: IDLE and RUN, with an internal counter cnt[W-1:0] and a pending register (pend_vld, pend_div).
REQ-016 IDLE -> RUN SHALL occur on the first edge at which run=1; cnt SHALL be 0 after that edge.
REQ-017 RUN -> IDLE SHALL occur on the first edge at which run=0; the stop is immediate (mid-period). cnt, tick and phase SHALL be 0 after that edge.
REQ-018 In RUN, cnt SHALL advance 0,1,...,cur_div-1,0,... and SHALL wrap to 0 after cur_div-1.
REQ-019 tick SHALL be 1 exactly in cycles where state=RUN and cnt=0; its first assertion is the cycle after the edge that sampled run=1.
REQ-020 phase SHALL be 1 in RUN when cnt < (cur_div+1)>>1, and 0 otherwise; for example, div 5 gives 3 high / 2 low and div 4 gives 2 high / 2 low.
REQ-021 busy SHALL equal (state==RUN).
REQ-022 A handshake SHALL complete on any edge with cfg_valid=1 and cfg_ready=1.
REQ-023 cfg_ready SHALL be 1 exactly when pend_vld=0.
REQ-024 A handshake with cfg_div >= 2 SHALL set pend_vld=1 and pend_div=cfg_div.
REQ-025 A handshake with cfg_div < 2 SHALL leave the pending register unchanged and SHALL pulse cfg_err for one cycle, starting the cycle after the handshake.
REQ-026 In IDLE, a pending divisor SHALL be applied on the next edge: cur_div=pend_div and pend_vld=0.
REQ-027 In RUN, a pending divisor SHALL be applied only on the edge where cnt wraps from cur_div-1 to 0, so no period is truncated or stretched.
REQ-028 A divisor accepted on the same edge as a wrap SHALL NOT take effect at that wrap; it SHALL take effect at the following boundary.
REQ-029 If the IDLE -> RUN transition and a pending apply fall on the same edge, the new divisor SHALL govern the first period.
REQ-030 While cfg_ready=0, cfg_valid SHALL be ignored.

Reset
REQ-031 On reset=1 at an edge, the block SHALL set: state=IDLE, cnt=0, cur_div=DEF_DIV, pend_vld=0, tick=0, phase=0, busy=0, cfg_err=0, cfg_ready=1.
REQ-032 Reset SHALL take priority over run and over any handshake in the same cycle, including mid-period; a pending divisor is discarded.

Verification
REQ-033 Reset, then hold run=1 for 20 cycles -> tick period 5; phase pattern 1,1,1,0,0 repeating; busy=1; cur_div=5.
REQ-034 In RUN with div 5, offer cfg_div=4 at cnt=2 -> cfg_ready=0 until the wrap; the current period completes 5 cycles; the next period is 4 cycles with phase 1,1,0,0; cur_div=4 from the wrap.
REQ-035 Offer cfg_div=1, then cfg_div=0 -> one cfg_err pulse each; cur_div is unchanged; cfg_ready stays 1.
REQ-036 In IDLE, offer cfg_div=3, then raise run the next cycle -> the first period is 3 cycles with phase 1,1,0.
REQ-037 Drop run at cnt=3 (div 5) -> IDLE after the next edge; tick=phase=0; re-raise run -> tick again one cycle later with cnt restarting at 0.
REQ-038 Assert reset mid-period with a divisor pending -> all outputs at their reset values; cur_div=5; the pending divisor is lost.

Source files
------------

// File: rtl/clk_div_sched_if.sv
// Control/status bundle for clk_div_sched: run request, divisor handshake,
// and the divided-clock status outputs.
interface clk_div_sched_if #(
    parameter int W = 16
);
    logic         run;
    logic         cfg_valid;
    logic [W-1:0] cfg_div;
    logic         cfg_ready;
    logic         tick;
    logic         phase;
    logic [W-1:0] cur_div;
    logic         cfg_err;
    logic         busy;

    modport master (
        output run, cfg_valid, cfg_div,
        input  cfg_ready, tick, phase, cur_div, cfg_err, busy
    );

    modport slave (
        input  run, cfg_valid, cfg_div,
        output cfg_ready, tick, phase, cur_div, cfg_err, busy
    );
endinterface

// File: rtl/clk_div_sched.sv
// Programmable clock-enable divider: tick/phase pulses every cur_div cycles,
// with a one-deep pending divisor applied only on period boundaries.
module clk_div_sched #(
    parameter int          W       = 16,
    parameter int unsigned DEF_DIV = 5
) (
    input  logic            clk_in,
    input  logic            reset,
    clk_div_sched_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [W-1:0] DEF_DIV_W = W'(DEF_DIV);

    state_t       state_q, state_n;
    logic [W-1:0] cnt_q, cnt_n;
    logic [W-1:0] cur_div_q, cur_div_n;
    logic         pend_vld_q, pend_vld_n;
    logic [W-1:0] pend_div_q, pend_div_n;

    // Output flops: each holds the decode of the *next* state so outputs
    // never depend combinationally on inputs.
    logic         tick_q, tick_n;
    logic         phase_q, phase_n;
    logic         busy_q, busy_n;
    logic         cfg_err_q, cfg_err_n;
    logic         cfg_ready_q, cfg_ready_n;

    logic         hs;
    logic         wrap;
    logic [W:0]   half_n;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_n    = state_q;
        cnt_n      = cnt_q;
        cur_div_n  = cur_div_q;
        pend_vld_n = pend_vld_q;
        pend_div_n = pend_div_q;

        hs   = bus.cfg_valid && cfg_ready_q;
        wrap = (cnt_q == (cur_div_q - W'(1)));

        case (state_q)
            IDLE: begin
                if (pend_vld_q) begin
                    cur_div_n  = pend_div_q;
                    pend_vld_n = 1'b0;
                end
                cnt_n = '0;
                if (bus.run) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (!bus.run) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (wrap) begin
                    cnt_n = '0;
                    if (pend_vld_q) begin
                        cur_div_n  = pend_div_q;
                        pend_vld_n = 1'b0;
                    end
                end else begin
                    cnt_n = cnt_q + W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // A handshake only happens with the pending slot empty, so it can never
        // collide with an apply above; a divisor taken on a wrap waits a period.
        if (hs && (bus.cfg_div >= W'(2))) begin
            pend_vld_n = 1'b1;
            pend_div_n = bus.cfg_div;
        end
        cfg_err_n = hs && (bus.cfg_div < W'(2));

        // Extra bit keeps (div+1)>>1 correct at div = 2^W-1.
        half_n      = ({1'b0, cur_div_n} + (W + 1)'(1)) >> 1;
        tick_n      = (state_n == RUN) && (cnt_n == '0);
        phase_n     = (state_n == RUN) && ({1'b0, cnt_n} < half_n);
        busy_n      = (state_n == RUN);
        cfg_ready_n = !pend_vld_n;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cur_div_q   <= DEF_DIV_W;
            pend_vld_q  <= 1'b0;
            pend_div_q  <= DEF_DIV_W;
            tick_q      <= 1'b0;
            phase_q     <= 1'b0;
            busy_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            cur_div_q   <= cur_div_n;
            pend_vld_q  <= pend_vld_n;
            pend_div_q  <= pend_div_n;
            tick_q      <= tick_n;
            phase_q     <= phase_n;
            busy_q      <= busy_n;
            cfg_err_q   <= cfg_err_n;
            cfg_ready_q <= cfg_ready_n;
        end
    end

    assign bus.tick      = tick_q;
    assign bus.phase     = phase_q;
    assign bus.busy      = busy_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.cfg_ready = cfg_ready_q;
    assign bus.cur_div   = cur_div_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: directed scenarios plus a randomized
// run against a period/position reference model.
module tb_clk_div_sched;

    localparam int W   = 16;
    localparam int DEF = 5;

    logic clk_in = 1'b0;
    logic reset;

    clk_div_sched_if #(.W(W)) bus ();

    clk_div_sched #(.W(W), .DEF_DIV(DEF)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Reference model: running flag, position inside the current period,
    // divisor in effect, and a queue holding at most one accepted divisor.
    bit m_running;
    int m_pos;
    int m_div;
    int m_pend[$];
    bit m_err;

    function automatic bit exp_tick();
        return m_running && (m_pos == 0);
    endfunction

    function automatic bit exp_phase();
        return m_running && (m_pos < (m_div + 1) / 2);
    endfunction

    task automatic step();
        bit acc;
        int cd;
        @(posedge clk_in);
        acc = bus.cfg_valid && (m_pend.size() == 0);
        cd  = int'(bus.cfg_div);
        if (reset) begin
            m_running = 0;
            m_pos     = 0;
            m_div     = DEF;
            m_err     = 0;
            m_pend.delete();
        end else begin
            m_err = acc && (cd < 2);
            if (!m_running) begin
                if (m_pend.size() > 0) m_div = m_pend.pop_front();
                m_running = bus.run;
                m_pos     = 0;
            end else if (!bus.run) begin
                m_running = 0;
                m_pos     = 0;
            end else begin
                m_pos = (m_pos + 1) % m_div;
                if (m_pos == 0 && m_pend.size() > 0) m_div = m_pend.pop_front();
            end
            if (acc && cd >= 2) m_pend.push_back(cd);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; bus.run = 1; bus.cfg_valid = 1; bus.cfg_div = 9;
        step(); step();
        bus.run = 0; bus.cfg_valid = 0;
        checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %0b exp 0", bus.tick); end
        checks++; if (bus.phase !== 1'b0) begin errors++; $display("FAIL rst_phase: got %0b exp 0", bus.phase); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b exp 0", bus.busy); end
        checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b exp 0", bus.cfg_err); end
        checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b exp 1", bus.cfg_ready); end
        checks++; if (bus.cur_div !== W'(DEF)) begin errors++; $display("FAIL rst_div: got %0d exp %0d", bus.cur_div, DEF); end
        reset = 0;
    endtask

    task automatic test_default_run();
        bus.run = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if (bus.tick !== 1'((i % 5) == 0)) begin errors++; $display("FAIL dflt_tick[%0d]: got %0b exp %0b", i, bus.tick, (i % 5) == 0); end
            checks++; if (bus.phase !== 1'((i % 5) < 3)) begin errors++; $display("FAIL dflt_phase[%0d]: got %0b exp %0b", i, bus.phase, (i % 5) < 3); end
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL dflt_busy[%0d]: got %0b exp 1", i, bus.busy); end
            checks++; if (bus.cur_div !== W'(5)) begin errors++; $display("FAIL dflt_div[%0d]: got %0d exp 5", i, bus.cur_div); end
        end
    endtask

    task automatic test_reconfig();
        bit exp_t[7] = '{0, 0, 1, 0, 0, 0, 1};
        bit exp_p[7] = '{0, 0, 1, 1, 0, 0, 1};
        int exp_d[7] = '{5, 5, 4, 4, 4, 4, 4};
        bit exp_r[7] = '{0, 0, 1, 1, 1, 1, 1};
        int n = 0;
        while (m_pos != 2 && n < 10) begin step(); n++; end
        checks++; if (m_pos != 2) begin errors++; $display("FAIL recfg_align: got pos %0d exp 2", m_pos); end
        bus.cfg_valid = 1; bus.cfg_div = 4;
        for (int k = 0; k < 7; k++) begin
            step();
            bus.cfg_valid = 0;
            checks++; if (bus.tick !== exp_t[k]) begin errors++; $display("FAIL recfg_tick[%0d]: got %0b exp %0b", k, bus.tick, exp_t[k]); end
            checks++; if (bus.phase !== exp_p[k]) begin errors++; $display("FAIL recfg_phase[%0d]: got %0b exp %0b", k, bus.phase, exp_p[k]); end
            checks++; if (bus.cur_div !== W'(exp_d[k])) begin errors++; $display("FAIL recfg_div[%0d]: got %0d exp %0d", k, bus.cur_div, exp_d[k]); end
            checks++; if (bus.cfg_ready !== exp_r[k]) begin errors++; $display("FAIL recfg_ready[%0d]: got %0b exp %0b", k, bus.cfg_ready, exp_r[k]); end
        end
    endtask

    task automatic test_illegal();
        bit exp_e[4] = '{1, 0, 1, 0};
        int vals[4]  = '{1, -1, 0, -1};
        for (int k = 0; k < 4; k++) begin
            bus.cfg_valid = (vals[k] >= 0);
            bus.cfg_div   = (vals[k] >= 0) ? W'(vals[k]) : '0;
            step();
            bus.cfg_valid = 0;
            checks++; if (bus.cfg_err !== exp_e[k]) begin errors++; $display("FAIL ill_err[%0d]: got %0b exp %0b", k, bus.cfg_err, exp_e[k]); end
            checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL ill_ready[%0d]: got %0b exp 1", k, bus.cfg_ready); end
            checks++; if (bus.cur_div !== W'(4)) begin errors++; $display("FAIL ill_div[%0d]: got %0d exp 4", k, bus.cur_div); end
        end
    endtask

    task automatic test_stop_restart();
        int n = 0;
        bus.cfg_valid = 1; bus.cfg_div = 5;
        step();
        bus.cfg_valid = 0;
        while (!(m_div == 5 && m_pos == 3) && n < 20) begin step(); n++; end
        checks++; if (!(m_div == 5 && m_pos == 3)) begin errors++; $display("FAIL stop_align: got div %0d pos %0d exp div 5 pos 3", m_div, m_pos); end
        bus.run = 0;
        step();
        checks++; if ({bus.busy, bus.tick, bus.phase} !== 3'b000) begin errors++; $display("FAIL stop_outs: got %b exp 000", {bus.busy, bus.tick, bus.phase}); end
        checks++; if (bus.cur_div !== W'(5)) begin errors++; $display("FAIL stop_div: got %0d exp 5", bus.cur_div); end
        step();
        checks++; if ({bus.busy, bus.tick, bus.phase} !== 3'b000) begin errors++; $display("FAIL stop_idle: got %b exp 000", {bus.busy, bus.tick, bus.phase}); end
        bus.run = 1;
        step();
        checks++; if ({bus.busy, bus.tick, bus.phase} !== 3'b111) begin errors++; $display("FAIL restart_first: got %b exp 111", {bus.busy, bus.tick, bus.phase}); end
        step();
        checks++; if ({bus.busy, bus.tick, bus.phase} !== 3'b101) begin errors++; $display("FAIL restart_second: got %b exp 101", {bus.busy, bus.tick, bus.phase}); end
    endtask

    task automatic test_idle_cfg();
        bit exp_t[4] = '{1, 0, 0, 1};
        bit exp_p[4] = '{1, 1, 0, 1};
        bus.run = 0;
        step();
        bus.cfg_valid = 1; bus.cfg_div = 3;
        step();
        bus.cfg_valid = 0; bus.run = 1;
        checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL idlecfg_ready: got %0b exp 0", bus.cfg_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idlecfg_busy: got %0b exp 0", bus.busy); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (bus.tick !== exp_t[k]) begin errors++; $display("FAIL idlecfg_tick[%0d]: got %0b exp %0b", k, bus.tick, exp_t[k]); end
            checks++; if (bus.phase !== exp_p[k]) begin errors++; $display("FAIL idlecfg_phase[%0d]: got %0b exp %0b", k, bus.phase, exp_p[k]); end
            checks++; if (bus.cur_div !== W'(3)) begin errors++; $display("FAIL idlecfg_div[%0d]: got %0d exp 3", k, bus.cur_div); end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (m_pos != 0 && n < 10) begin step(); n++; end
        bus.cfg_valid = 1; bus.cfg_div = 7;
        step();
        bus.cfg_valid = 0;
        checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL rmid_pending: got ready %0b exp 0", bus.cfg_ready); end
        reset = 1;
        step();
        reset = 0; bus.run = 0;
        checks++; if ({bus.busy, bus.tick, bus.phase, bus.cfg_err, bus.cfg_ready} !== 5'b00001) begin
            errors++; $display("FAIL rmid_outs: got %b exp 00001", {bus.busy, bus.tick, bus.phase, bus.cfg_err, bus.cfg_ready}); end
        checks++; if (bus.cur_div !== W'(5)) begin errors++; $display("FAIL rmid_div: got %0d exp 5", bus.cur_div); end
        step(); step();
        checks++; if (bus.cur_div !== W'(5)) begin errors++; $display("FAIL rmid_lost: got %0d exp 5", bus.cur_div); end
        checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %0b exp 1", bus.cfg_ready); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 79) == 0);
            bus.run       = ($urandom_range(0, 11) != 0);
            bus.cfg_valid = ($urandom_range(0, 5) == 0);
            bus.cfg_div   = W'($urandom_range(0, 9));
            step();
            checks++; if (bus.tick !== exp_tick()) begin errors++; $display("FAIL rnd_tick[%0d]: got %0b exp %0b", i, bus.tick, exp_tick()); end
            checks++; if (bus.phase !== exp_phase()) begin errors++; $display("FAIL rnd_phase[%0d]: got %0b exp %0b", i, bus.phase, exp_phase()); end
            checks++; if (bus.busy !== m_running) begin errors++; $display("FAIL rnd_busy[%0d]: got %0b exp %0b", i, bus.busy, m_running); end
            checks++; if (bus.cur_div !== W'(m_div)) begin errors++; $display("FAIL rnd_div[%0d]: got %0d exp %0d", i, bus.cur_div, m_div); end
            checks++; if (bus.cfg_ready !== 1'(m_pend.size() == 0)) begin errors++; $display("FAIL rnd_ready[%0d]: got %0b exp %0b", i, bus.cfg_ready, m_pend.size() == 0); end
            checks++; if (bus.cfg_err !== m_err) begin errors++; $display("FAIL rnd_err[%0d]: got %0b exp %0b", i, bus.cfg_err, m_err); end
        end
        reset = 0;
    endtask

    initial begin
        reset = 1; bus.run = 0; bus.cfg_valid = 0; bus.cfg_div = '0;
        m_running = 0; m_pos = 0; m_div = DEF; m_err = 0;
        test_reset();
        test_default_run();
        test_reconfig();
        test_illegal();
        test_stop_restart();
        test_idle_cfg();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
